// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRAIN   = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } sys_state_t;

   localparam int REG_ZERO             = 0;
   localparam int DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/hazard_ctrl_syscall_fsm.sv
// Syscall drain-and-handshake sequencer: freezes fetch while the pipeline
// drains and an external handler services the request.
module syscall_fsm
   import hazard_pkg::*;
#(
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        syscall,
   input  logic        stall,
   input  logic        ack,
   output logic        flag,
   output logic        req,
   output logic [31:0] count
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   sys_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      count_reg, count_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      count_next = count_reg;
      flag       = 1'b0;
      req        = 1'b0;
      case (state_reg)
         IDLE: begin
            // A syscall stuck behind a hazard waits until its operands settle.
            if (syscall && !stall) begin
               state_next = DRAIN;
               cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            flag = 1'b1;
            if (cnt_reg == '0) state_next = REQ;
            else               cnt_next   = cnt_reg - CNT_W'(1);
         end
         REQ: begin
            flag = 1'b1;
            req  = 1'b1;
            if (ack) begin
               state_next = RELEASE;
               count_next = count_reg + 32'd1;
            end
         end
         RELEASE: begin
            // One unfrozen cycle lets fetch move past the syscall before rearming.
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stall detection
// plus the syscall freeze sequencer, driving PC/IF-ID hold and ID/EX bubble.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W        = 5,
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_uses_rs_i,
   input  logic             id_uses_rt_i,
   input  logic             id_branch_i,
   input  logic             id_syscall_i,
   input  logic             ex_regwrite_i,
   input  logic             ex_memread_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             mem_regwrite_i,
   input  logic             mem_memread_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic             syscall_ack_i,
   output logic             load_stall_o,
   output logic             branch_stall_o,
   output logic             syscall_flag_o,
   output logic             id_ex_bubble_o,
   output logic             syscall_req_o,
   output logic [31:0]      syscall_count_o
);

   function automatic logic reg_match(
      input logic [REG_W-1:0] rd,
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rt,
      input logic             uses_rs,
      input logic             uses_rt
   );
      return (rd != REG_W'(REG_ZERO)) &&
             ((uses_rs && (rd == rs)) || (uses_rt && (rd == rt)));
   endfunction

   logic ex_match;
   logic mem_match;

   assign ex_match  = reg_match(ex_rd_i,  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i);
   assign mem_match = reg_match(mem_rd_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i);

   // MEM ALU results reach the ID comparator through forwarding; only MEM loads stall.
   logic unused_mem_regwrite;
   assign unused_mem_regwrite = mem_regwrite_i;

   assign load_stall_o   = ex_memread_i & ex_match;
   assign branch_stall_o = id_branch_i &
                           ((ex_regwrite_i & ex_match) | (mem_memread_i & mem_match));
   assign id_ex_bubble_o = load_stall_o | branch_stall_o | syscall_flag_o;

   syscall_fsm #(
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) u_syscall_fsm (
      .clk     (clk),
      .reset   (reset),
      .syscall (id_syscall_i),
      .stall   (load_stall_o | branch_stall_o),
      .ack     (syscall_ack_i),
      .flag    (syscall_flag_o),
      .req     (syscall_req_o),
      .count   (syscall_count_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
   logic        id_uses_rs, id_uses_rt, id_branch, id_syscall;
   logic        ex_regwrite, ex_memread, mem_regwrite, mem_memread, syscall_ack;
   logic        load_stall, branch_stall, syscall_flag, id_ex_bubble, syscall_req;
   logic [31:0] syscall_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic        ld, br, fl, bub, rq;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t cur;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs_i         (id_rs),
      .id_rt_i         (id_rt),
      .id_uses_rs_i    (id_uses_rs),
      .id_uses_rt_i    (id_uses_rt),
      .id_branch_i     (id_branch),
      .id_syscall_i    (id_syscall),
      .ex_regwrite_i   (ex_regwrite),
      .ex_memread_i    (ex_memread),
      .ex_rd_i         (ex_rd),
      .mem_regwrite_i  (mem_regwrite),
      .mem_memread_i   (mem_memread),
      .mem_rd_i        (mem_rd),
      .syscall_ack_i   (syscall_ack),
      .load_stall_o    (load_stall),
      .branch_stall_o  (branch_stall),
      .syscall_flag_o  (syscall_flag),
      .id_ex_bubble_o  (id_ex_bubble),
      .syscall_req_o   (syscall_req),
      .syscall_count_o (syscall_count)
   );

   // Monitor: the DUT presents a full output vector every cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         checks++;
         if ({load_stall, branch_stall, syscall_flag, id_ex_bubble, syscall_req} !==
             {cur.ld, cur.br, cur.fl, cur.bub, cur.rq} || syscall_count !== cur.cnt) begin
            errors++;
            $display("FAIL %s: got ld=%b br=%b fl=%b bub=%b rq=%b cnt=%0d, want ld=%b br=%b fl=%b bub=%b rq=%b cnt=%0d",
                     cur.name, load_stall, branch_stall, syscall_flag, id_ex_bubble,
                     syscall_req, syscall_count, cur.ld, cur.br, cur.fl, cur.bub,
                     cur.rq, cur.cnt);
         end else begin
            $display("ok   %s: ld=%b br=%b fl=%b bub=%b rq=%b cnt=%0d", cur.name,
                     load_stall, branch_stall, syscall_flag, id_ex_bubble,
                     syscall_req, syscall_count);
         end
      end
   end

   task automatic hz(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic br, input logic exw, input logic exr,
                     input logic [4:0] exd, input logic mw, input logic mr,
                     input logic [4:0] md);
      id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; id_branch = br;
      ex_regwrite = exw; ex_memread = exr; ex_rd = exd;
      mem_regwrite = mw; mem_memread = mr; mem_rd = md;
   endtask

   task automatic step(input string nm, input logic ld, input logic br, input logic fl,
                       input logic bub, input logic rq, input logic [31:0] cnt);
      exp_t e;
      e.name = nm; e.ld = ld; e.br = br; e.fl = fl; e.bub = bub; e.rq = rq; e.cnt = cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; id_syscall = 1'b0; syscall_ack = 1'b0;
      hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      step("reset_state", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Load-use and register-zero cases
      hz(8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 0);  step("load_use_rs",   1, 0, 0, 1, 0, 0);
      hz(8, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);  step("load_rd_zero",  0, 0, 0, 0, 0, 0);
      hz(0, 8, 0, 1, 0, 0, 1, 8, 0, 0, 0);  step("load_use_rt",   1, 0, 0, 1, 0, 0);
      hz(8, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);  step("load_rs_unused",0, 0, 0, 0, 0, 0);

      // Branch operand hazards
      hz(0, 9, 0, 1, 1, 1, 0, 9, 0, 0, 0);  step("br_ex_alu",     0, 1, 0, 1, 0, 0);
      hz(0, 9, 0, 1, 1, 0, 0, 0, 1, 0, 9);  step("br_mem_alu",    0, 0, 0, 0, 0, 0);
      hz(0, 9, 0, 1, 1, 0, 0, 0, 1, 1, 9);  step("br_mem_load",   0, 1, 0, 1, 0, 0);
      hz(0, 9, 0, 1, 1, 1, 1, 9, 0, 0, 0);  step("br_and_load",   1, 1, 0, 1, 0, 0);
      hz(0, 9, 0, 1, 0, 0, 0, 0, 1, 1, 9);  step("nobr_mem_load", 0, 0, 0, 0, 0, 0);

      // Syscall blocked by a load-use stall, then full handshake
      id_syscall = 1'b1;
      hz(8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 0);  step("sys_blocked0",  1, 0, 0, 1, 0, 0);
                                            step("sys_blocked1",  1, 0, 0, 1, 0, 0);
      hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("sys_clear",     0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)           step($sformatf("sys_drain%0d", i), 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++)           step($sformatf("sys_req%0d", i),   0, 0, 1, 1, 1, 0);
      syscall_ack = 1'b1;                   step("sys_req_ack",   0, 0, 1, 1, 1, 0);
      syscall_ack = 1'b0;                   step("sys_release",   0, 0, 0, 0, 0, 1);
      id_syscall = 1'b0;                    step("sys_idle",      0, 0, 0, 0, 0, 1);

      // Stray ack in IDLE leaves the count alone
      syscall_ack = 1'b1;                   step("stray_ack0",    0, 0, 0, 0, 0, 1);
                                            step("stray_ack1",    0, 0, 0, 0, 0, 1);
      syscall_ack = 1'b0;

      // Ack in the first REQ cycle is accepted
      id_syscall = 1'b1;                    step("s2_idle",       0, 0, 0, 0, 0, 1);
      id_syscall = 1'b0;
      for (int i = 0; i < 3; i++)           step($sformatf("s2_drain%0d", i), 0, 0, 1, 1, 0, 1);
      syscall_ack = 1'b1;                   step("s2_req_ack",    0, 0, 1, 1, 1, 1);
      syscall_ack = 1'b0;                   step("s2_release",    0, 0, 0, 0, 0, 2);
                                            step("s2_done",       0, 0, 0, 0, 0, 2);

      // Reset while requesting; a late ack must be ignored
      id_syscall = 1'b1;                    step("s3_idle",       0, 0, 0, 0, 0, 2);
      id_syscall = 1'b0;
      for (int i = 0; i < 3; i++)           step($sformatf("s3_drain%0d", i), 0, 0, 1, 1, 0, 2);
                                            step("s3_req",        0, 0, 1, 1, 1, 2);
      reset = 1'b1;                         step("s3_req_reset",  0, 0, 1, 1, 1, 2);
      reset = 1'b0; syscall_ack = 1'b1;     step("s3_after_rst",  0, 0, 0, 0, 0, 0);
      syscall_ack = 1'b0;                   step("s3_late_ack",   0, 0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the fetch stage's stall inputs. It detects load-use and branch-operand hazards from ID/EX/MEM register fields. It also runs a syscall drain-and-handshake state machine that freezes fetch while an external handler services the syscall. It sits beside the ID stage. Its stall outputs feed the program counter, the IF/ID register and the ID/EX bubble insertion.

## Interface
Parameters:
- REG_W, 5, register-index width
- DRAIN_CYCLES, 3, cycles to empty EX/MEM/WB before a syscall request

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_rs_i, id_rt_i  in  REG_W  source register indices of instruction in ID
- id_uses_rs_i, id_uses_rt_i  in  1  instruction in ID reads rs / rt
- id_branch_i  in  1  conditional branch in ID (compare resolved in ID)
- id_syscall_i  in  1  syscall in ID
- ex_regwrite_i, ex_memread_i  in  1  EX-stage instruction writes a register / is a load
- ex_rd_i  in  REG_W  EX destination register
- mem_regwrite_i, mem_memread_i  in  1  MEM-stage equivalents
- mem_rd_i  in  REG_W  MEM destination register
- syscall_ack_i  in  1  handler completion acknowledge
- load_stall_o  out  1  load-use stall (to PC and IF/ID hold)
- branch_stall_o  out  1  branch operand not ready (to PC and IF/ID hold)
- syscall_flag_o  out  1  syscall freeze (to PC and IF/ID hold)
- id_ex_bubble_o  out  1  insert NOP into ID/EX
- syscall_req_o  out  1  request to handler
- syscall_count_o  out  32  completed syscalls

## Operation
- match(rd) means: rd != 0, and either (id_uses_rs_i and rd == id_rs_i) or (id_uses_rt_i and rd == id_rt_i).
- load_stall_o = ex_memread_i & match(ex_rd_i). It is combinational.
- branch_stall_o = id_branch_i & ((ex_regwrite_i & match(ex_rd_i)) | (mem_memread_i & match(mem_rd_i))).
  - MEM ALU results are forwarded, so they do not stall.
  - MEM load data is not yet available, so it does.
- Load and branch stalls may assert together. Both are reported; the consumer ORs them.
- id_ex_bubble_o = load_stall_o | branch_stall_o | syscall_flag_o.
- Syscall FSM states are IDLE, DRAIN, REQ and RELEASE.
  - IDLE: if id_syscall_i & !load_stall_o & !branch_stall_o, go to DRAIN and load drain counter with DRAIN_CYCLES-1.
  - DRAIN: syscall_flag_o=1. Counter decrements each cycle. At 0, go to REQ.
  - REQ: syscall_flag_o=1 and syscall_req_o=1. Hold until syscall_ack_i=1. On ack: go to RELEASE and increment syscall_count_o (wraps modulo 2^32).
  - RELEASE: all syscall outputs 0 for one cycle, so fetch advances past the syscall. id_syscall_i is ignored in this cycle. Next state is IDLE.
- syscall_ack_i is ignored outside REQ.

## Timing
- Hazard outputs are same-cycle combinational from inputs. There are no registered paths.
- Syscall latency: the FSM samples id_syscall_i at edge N.
  - syscall_flag_o rises after edge N.
  - syscall_req_o rises after edge N+DRAIN_CYCLES.
  - The ack-sampling edge moves the FSM to RELEASE.
  - The flag returns to IDLE one cycle after RELEASE.
- Reset values: FSM IDLE, counter 0, syscall_count_o 0, syscall_flag_o 0, syscall_req_o 0.
- Reset asserted in any state returns the FSM to IDLE on the same edge and drops req/flag. The count is cleared.
- An ack in the same cycle req first rises is accepted.
- The count increments exactly once per handshake.

## Structure
- Shared package hazard_pkg holds:
  - the FSM state enum (IDLE, DRAIN, REQ, RELEASE);
  - the REG_ZERO constant;
  - the default DRAIN_CYCLES.
- One sub-module, syscall_fsm, holds:
  - the state register, drain counter, syscall count and req/flag generation.
- The top level holds the combinational match logic and the bubble OR.

## Test plan
- Load-use: ex_memread_i=1, ex_rd_i=8, id_rs_i=8, id_uses_rs_i=1. Expect load_stall_o=1 and id_ex_bubble_o=1. With ex_rd_i=0: expect all 0.
- Branch vs ALU in EX: id_branch_i=1, id_rt_i=9, id_uses_rt_i=1, ex_regwrite_i=1, ex_rd_i=9. Expect branch_stall_o=1.
  - Same case with the producer in MEM as ALU (mem_memread_i=0): expect 0.
  - Same case with the producer in MEM as a load: expect 1.
- Syscall handshake: pulse id_syscall_i held in ID.
  - Expect flag high 3 cycles before req.
  - Ack after 5 REQ cycles.
  - Expect one RELEASE cycle with flag 0, then IDLE, and syscall_count_o=1.
- Syscall blocked: id_syscall_i=1 together with load_stall_o=1. Expect the FSM to stay IDLE until the stall clears.
- Reset mid-REQ: assert reset while syscall_req_o=1. Expect req=0, flag=0 and count=0 on the next cycle. A late ack is ignored.
- Stray ack in IDLE: count unchanged.
